// File: rtl/display_mux_ctrl.sv
// display_mux_ctrl: two-digit seven-segment multiplexer with dead-time; define LZ_BLANK_EN for leading-zero suppression
module display_mux_ctrl #(
  parameter int REFRESH_DIV = 24000,
  parameter int DEAD_CYCLES = 480
) (
  input  logic       int_osc,
  input  logic       reset,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  output logic [3:0] hex,
  output logic [1:0] an,
  output logic       blank,
  output logic       frame_tick
);
  localparam int MAXN = REFRESH_DIV > DEAD_CYCLES ? REFRESH_DIV : DEAD_CYCLES;
  localparam int W = $clog2(MAXN + 1);
  localparam logic [W-1:0] SHOW_LAST = W'(REFRESH_DIV - 1);
  localparam logic [W-1:0] DEAD_LAST = W'(DEAD_CYCLES > 0 ? DEAD_CYCLES - 1 : 0);
  typedef enum logic [1:0] {SHOW0, DEAD0, SHOW1, DEAD1} state_t;
  state_t state, nxt;
  logic [W-1:0] cnt, cnt_d;
  logic [7:0] snap, snap_d;
  logic [3:0] hex_d;
  logic [1:0] an_d;
  logic done, enter0, lz;
  // State, slot counter, snapshot and all outputs register together so they change on one edge
  always_ff @(posedge int_osc or negedge reset)
    if (!reset) begin
      state      <= DEAD1;
      cnt        <= '0;
      snap       <= '0;
      hex        <= 4'h0;
      an         <= 2'b11;
      blank      <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      state      <= nxt;
      cnt        <= cnt_d;
      snap       <= snap_d;
      hex        <= hex_d;
      an         <= an_d;
      blank      <= an_d == 2'b11;
      frame_tick <= enter0;
    end
  // Advance to the next slot when the counter reaches the last cycle of the current one
  always_comb begin
    done  = (state == SHOW0 || state == SHOW1) ? cnt == SHOW_LAST : cnt == DEAD_LAST;
    nxt   = !done ? state :
            state == SHOW0 ? (DEAD_CYCLES == 0 ? SHOW1 : DEAD0) :
            state == DEAD0 ? SHOW1 :
            state == SHOW1 ? (DEAD_CYCLES == 0 ? SHOW0 : DEAD1) : SHOW0;
    cnt_d = nxt != state ? '0 : cnt + W'(1);
  end
  // Next outputs derive from the next state; hex holds through dead slots to keep the decoder quiet
  always_comb begin
    enter0 = nxt == SHOW0 && state != SHOW0;
    snap_d = enter0 ? {s1, s0} : snap;
`ifdef LZ_BLANK_EN
    lz     = snap_d[7:4] == 4'h0;
`else
    lz     = 1'b0;
`endif
    an_d   = nxt == SHOW0 ? 2'b10 : (nxt == SHOW1 && !lz) ? 2'b01 : 2'b11;
    hex_d  = nxt == SHOW0 ? snap_d[3:0] : nxt == SHOW1 ? snap_d[7:4] : hex;
  end
endmodule
